// File: rtl/gate_ctrl_pkg.sv
// Shared types and default constants for the single-lane parking gate controller.
// The controller and its timer import everything from here.
package gate_ctrl_pkg;

    localparam int unsigned OPEN_CYCLES_DEF  = 32'd4;
    localparam int unsigned PASS_TIMEOUT_DEF = 32'd16;
    localparam int unsigned CLOSE_CYCLES_DEF = 32'd4;
    localparam int unsigned CAPACITY_DEF     = 32'd9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_OPEN   = 3'd1,
        ST_PASS   = 3'd2,
        ST_COMMIT = 3'd3,
        ST_CLOSE  = 3'd4
    } gate_state_t;

    typedef enum logic {
        DIR_ENTRY = 1'b0,
        DIR_EXIT  = 1'b1
    } gate_dir_t;

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

    // A state lasting N cycles loads N-1 so that done is seen in its last cycle.
    function automatic int unsigned load_count(input int unsigned cycles);
        return (cycles > 32'd0) ? (cycles - 32'd1) : 32'd0;
    endfunction

endpackage

// File: rtl/gate_controller_cycle_timer.sv
// Loadable, saturating down-counter; done is high while the count sits at zero.
// Shared by every timed state of the gate controller.
module cycle_timer
    import gate_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 32'd5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1'b1);

    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic             done_r;

    // Next count: reload on request, otherwise step down and stick at zero.
    always_comb begin
        count_next_s = count_r;
        if (load) begin
            count_next_s = load_value;
        end else if (count_r != ZERO) begin
            count_next_s = count_r - ONE;
        end else begin
            count_next_s = ZERO;
        end
    end

    // Count and done flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= ZERO;
            done_r  <= 1'b1;
        end else begin
            count_r <= count_next_s;
            done_r  <= (count_next_s == ZERO);
        end
    end

    assign done = done_r;

endmodule

// File: rtl/gate_controller.sv
// Shared-barrier gate controller: arbitrates entry/exit requests, sequences the
// barrier through OPEN/PASS/COMMIT/CLOSE and reports committed cars to the park system.
module gate_controller
    import gate_ctrl_pkg::*;
#(
    parameter int unsigned OPEN_CYCLES  = OPEN_CYCLES_DEF,
    parameter int unsigned PASS_TIMEOUT = PASS_TIMEOUT_DEF,
    parameter int unsigned CLOSE_CYCLES = CLOSE_CYCLES_DEF,
    parameter int unsigned CAPACITY     = CAPACITY_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_req,
    input  logic       exit_req,
    input  logic       pass_sensor,
    input  logic       parking_full,
    input  logic [3:0] free_spots,
    output logic       car_in,
    output logic       car_out,
    output logic       barrier_up,
    output logic       entry_grant,
    output logic       exit_grant,
    output logic       timeout_err
);

    localparam int unsigned TIMER_W =
        $clog2(max3(OPEN_CYCLES, PASS_TIMEOUT, CLOSE_CYCLES)) + 32'd1;

    localparam logic [TIMER_W-1:0] OPEN_LOAD  = TIMER_W'(load_count(OPEN_CYCLES));
    localparam logic [TIMER_W-1:0] PASS_LOAD  = TIMER_W'(load_count(PASS_TIMEOUT));
    localparam logic [TIMER_W-1:0] CLOSE_LOAD = TIMER_W'(load_count(CLOSE_CYCLES));
    localparam logic [3:0]         CAPACITY_W = 4'(CAPACITY);

    gate_state_t        state_r;
    gate_state_t        state_next_s;
    gate_dir_t          active_dir_r;
    gate_dir_t          last_served_r;
    gate_dir_t          grant_dir_s;
    gate_dir_t          dir_next_s;
    logic               grant_valid_s;
    logic               sensor_d_r;
    logic               fall_s;
    logic               entry_ok_s;
    logic               exit_ok_s;
    logic               timer_load_s;
    logic [TIMER_W-1:0] timer_value_s;
    logic               timer_done_s;

    logic car_in_s, car_out_s, barrier_up_s, entry_grant_s, exit_grant_s, timeout_err_s;
    logic car_in_r, car_out_r, barrier_up_r, entry_grant_r, exit_grant_r, timeout_err_r;

    assign entry_ok_s = entry_req & ~parking_full;
    assign exit_ok_s  = exit_req & (free_spots < CAPACITY_W);
    assign fall_s     = sensor_d_r & ~pass_sensor;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic including round-robin arbitration in IDLE.
    always_comb begin
        state_next_s  = state_r;
        grant_valid_s = 1'b0;
        grant_dir_s   = DIR_ENTRY;
        case (state_r)
            ST_IDLE: begin
                if (entry_ok_s && exit_ok_s) begin
                    grant_valid_s = 1'b1;
                    grant_dir_s   = (last_served_r == DIR_EXIT) ? DIR_ENTRY : DIR_EXIT;
                end else if (entry_ok_s) begin
                    grant_valid_s = 1'b1;
                    grant_dir_s   = DIR_ENTRY;
                end else if (exit_ok_s) begin
                    grant_valid_s = 1'b1;
                    grant_dir_s   = DIR_EXIT;
                end else begin
                    grant_valid_s = 1'b0;
                end
                state_next_s = grant_valid_s ? ST_OPEN : ST_IDLE;
            end
            ST_OPEN: begin
                state_next_s = timer_done_s ? ST_PASS : ST_OPEN;
            end
            ST_PASS: begin
                // A falling edge in the final window cycle still wins over the timeout.
                if (fall_s) begin
                    state_next_s = ST_COMMIT;
                end else if (timer_done_s) begin
                    state_next_s = ST_CLOSE;
                end else begin
                    state_next_s = ST_PASS;
                end
            end
            ST_COMMIT: begin
                state_next_s = ST_CLOSE;
            end
            ST_CLOSE: begin
                state_next_s = timer_done_s ? ST_IDLE : ST_CLOSE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Timer reload on every state entry.
    always_comb begin
        timer_load_s = (state_next_s != state_r);
        case (state_next_s)
            ST_OPEN:  timer_value_s = OPEN_LOAD;
            ST_PASS:  timer_value_s = PASS_LOAD;
            ST_CLOSE: timer_value_s = CLOSE_LOAD;
            default:  timer_value_s = {TIMER_W{1'b0}};
        endcase
    end

    cycle_timer #(
        .WIDTH(TIMER_W)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .load      (timer_load_s),
        .load_value(timer_value_s),
        .done      (timer_done_s)
    );

    // Direction bookkeeping and pass_sensor edge register.
    always_ff @(posedge clk) begin
        if (rst) begin
            active_dir_r  <= DIR_ENTRY;
            last_served_r <= DIR_EXIT;
            sensor_d_r    <= 1'b0;
        end else begin
            sensor_d_r <= pass_sensor;
            if (grant_valid_s) begin
                active_dir_r <= grant_dir_s;
            end
            if (state_r == ST_COMMIT) begin
                last_served_r <= active_dir_r;
            end
        end
    end

    // Output decode from the next state so the registered outputs line up with the state.
    always_comb begin
        car_in_s      = 1'b0;
        car_out_s     = 1'b0;
        barrier_up_s  = 1'b0;
        entry_grant_s = 1'b0;
        exit_grant_s  = 1'b0;
        timeout_err_s = 1'b0;
        if (grant_valid_s) begin
            dir_next_s = grant_dir_s;
        end else begin
            dir_next_s = active_dir_r;
        end
        case (state_next_s)
            ST_OPEN, ST_PASS: begin
                barrier_up_s  = 1'b1;
                entry_grant_s = (dir_next_s == DIR_ENTRY);
                exit_grant_s  = (dir_next_s == DIR_EXIT);
            end
            ST_COMMIT: begin
                barrier_up_s  = 1'b1;
                entry_grant_s = (dir_next_s == DIR_ENTRY);
                exit_grant_s  = (dir_next_s == DIR_EXIT);
                car_in_s      = (dir_next_s == DIR_ENTRY);
                car_out_s     = (dir_next_s == DIR_EXIT);
            end
            ST_CLOSE: begin
                entry_grant_s = (dir_next_s == DIR_ENTRY);
                exit_grant_s  = (dir_next_s == DIR_EXIT);
                timeout_err_s = (state_r == ST_PASS);
            end
            ST_IDLE: begin
                barrier_up_s = 1'b0;
            end
            default: begin
                barrier_up_s = 1'b0;
            end
        endcase
    end

    // Output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            car_in_r      <= 1'b0;
            car_out_r     <= 1'b0;
            barrier_up_r  <= 1'b0;
            entry_grant_r <= 1'b0;
            exit_grant_r  <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            car_in_r      <= car_in_s;
            car_out_r     <= car_out_s;
            barrier_up_r  <= barrier_up_s;
            entry_grant_r <= entry_grant_s;
            exit_grant_r  <= exit_grant_s;
            timeout_err_r <= timeout_err_s;
        end
    end

    assign car_in      = car_in_r;
    assign car_out     = car_out_r;
    assign barrier_up  = barrier_up_r;
    assign entry_grant = entry_grant_r;
    assign exit_grant  = exit_grant_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_gate_controller.sv
// Directed bench for gate_controller; output vector order is
// {car_in, car_out, barrier_up, entry_grant, exit_grant, timeout_err}.
module tb_gate_controller;

    logic       clk;
    logic       rst;
    logic       entry_req;
    logic       exit_req;
    logic       pass_sensor;
    logic       parking_full;
    logic [3:0] free_spots;
    logic       car_in, car_out, barrier_up, entry_grant, exit_grant, timeout_err;
    logic [5:0] outs;

    int check_cnt = 0;
    int fail_cnt  = 0;
    int car_in_total  = 0;
    int car_out_total = 0;
    int timeout_total = 0;
    int overlap_total = 0;
    int snap_in, snap_out, snap_to;

    localparam logic [5:0] O_NONE      = 6'b000000;
    localparam logic [5:0] O_ENT_UP    = 6'b001100;
    localparam logic [5:0] O_ENT_CAR   = 6'b101100;
    localparam logic [5:0] O_ENT_DOWN  = 6'b000100;
    localparam logic [5:0] O_EXIT_UP   = 6'b001010;
    localparam logic [5:0] O_EXIT_CAR  = 6'b011010;
    localparam logic [5:0] O_EXIT_DOWN = 6'b000010;
    localparam logic [5:0] O_EXIT_TO   = 6'b000011;

    gate_controller #(
        .OPEN_CYCLES (4),
        .PASS_TIMEOUT(16),
        .CLOSE_CYCLES(4),
        .CAPACITY    (9)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .entry_req   (entry_req),
        .exit_req    (exit_req),
        .pass_sensor (pass_sensor),
        .parking_full(parking_full),
        .free_spots  (free_spots),
        .car_in      (car_in),
        .car_out     (car_out),
        .barrier_up  (barrier_up),
        .entry_grant (entry_grant),
        .exit_grant  (exit_grant),
        .timeout_err (timeout_err)
    );

    assign outs = {car_in, car_out, barrier_up, entry_grant, exit_grant, timeout_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (car_in) car_in_total <= car_in_total + 1;
        if (car_out) car_out_total <= car_out_total + 1;
        if (timeout_err) timeout_total <= timeout_total + 1;
        if ((entry_grant && exit_grant) || (car_in && car_out)) overlap_total <= overlap_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input string tag, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            tick();
            check_eq(tag, {26'd0, outs}, {26'd0, exp});
        end
    endtask

    initial begin
        rst = 1'b1; entry_req = 1'b0; exit_req = 1'b0; pass_sensor = 1'b0;
        parking_full = 1'b0; free_spots = 4'd9;
        expect_run("reset_outs", 3, O_NONE);
        rst = 1'b0;

        // Empty garage: exit request is never eligible.
        exit_req = 1'b1;
        expect_run("empty_no_grant", 12, O_NONE);
        exit_req = 1'b0;
        tick();

        // Entry only; request dropped right after the grant must not abort.
        snap_in = car_in_total; snap_out = car_out_total;
        entry_req = 1'b1;
        expect_run("entry_open1", 1, O_ENT_UP);
        entry_req = 1'b0;
        expect_run("entry_open", 4, O_ENT_UP);
        pass_sensor = 1'b1;
        expect_run("entry_pass", 3, O_ENT_UP);
        pass_sensor = 1'b0;
        expect_run("entry_commit", 1, O_ENT_CAR);
        expect_run("entry_close", 4, O_ENT_DOWN);
        expect_run("entry_idle", 2, O_NONE);
        check_eq("entry_car_in_cnt", car_in_total - snap_in, 1);
        check_eq("entry_car_out_cnt", car_out_total - snap_out, 0);

        // Full garage blocks entry; exit served with sensor toggling in OPEN.
        parking_full = 1'b1; free_spots = 4'd0; entry_req = 1'b1;
        expect_run("full_no_grant", 20, O_NONE);
        snap_out = car_out_total;
        exit_req = 1'b1;
        expect_run("exit_open1", 1, O_EXIT_UP);
        exit_req = 1'b0; pass_sensor = 1'b1;
        expect_run("exit_open2", 1, O_EXIT_UP);
        pass_sensor = 1'b0;
        expect_run("exit_open3", 1, O_EXIT_UP);
        pass_sensor = 1'b1;
        expect_run("exit_open4", 1, O_EXIT_UP);
        expect_run("exit_pass1", 1, O_EXIT_UP);
        pass_sensor = 1'b0;
        expect_run("exit_latency", 1, O_EXIT_CAR);
        expect_run("exit_close", 4, O_EXIT_DOWN);
        expect_run("full_still_blocked", 6, O_NONE);
        check_eq("exit_car_out_cnt", car_out_total - snap_out, 1);
        entry_req = 1'b0; parking_full = 1'b0;

        // Fresh reset, then simultaneous requests: entry first, exit after CLOSE.
        rst = 1'b1;
        expect_run("rst2_outs", 2, O_NONE);
        rst = 1'b0; free_spots = 4'd5; entry_req = 1'b1; exit_req = 1'b1;
        expect_run("rr_entry_open", 4, O_ENT_UP);
        pass_sensor = 1'b1;
        expect_run("rr_entry_pass", 1, O_ENT_UP);
        pass_sensor = 1'b0;
        expect_run("rr_entry_commit", 1, O_ENT_CAR);
        expect_run("rr_entry_close", 4, O_ENT_DOWN);
        expect_run("rr_gap_idle", 1, O_NONE);
        expect_run("rr_exit_grant", 1, O_EXIT_UP);
        entry_req = 1'b0; exit_req = 1'b0;

        // Exit transaction times out: sensor never falls.
        snap_in = car_in_total; snap_out = car_out_total; snap_to = timeout_total;
        expect_run("to_open", 3, O_EXIT_UP);
        expect_run("to_pass", 16, O_EXIT_UP);
        expect_run("to_pulse", 1, O_EXIT_TO);
        expect_run("to_close", 3, O_EXIT_DOWN);
        entry_req = 1'b1; exit_req = 1'b1;
        expect_run("to_idle_holdoff", 1, O_NONE);
        // Timeout left last-served at entry, so exit wins again.
        expect_run("rr_after_timeout", 1, O_EXIT_UP);
        entry_req = 1'b0; exit_req = 1'b0;
        check_eq("to_count", timeout_total - snap_to, 1);
        check_eq("to_no_car", (car_in_total - snap_in) + (car_out_total - snap_out), 0);

        // Reset in PASS while the sensor falls: no car pulse, everything drops.
        snap_out = car_out_total;
        expect_run("rp_open", 3, O_EXIT_UP);
        expect_run("rp_pass1", 1, O_EXIT_UP);
        pass_sensor = 1'b1;
        expect_run("rp_pass2", 1, O_EXIT_UP);
        rst = 1'b1; pass_sensor = 1'b0;
        expect_run("rp_reset_outs", 2, O_NONE);
        rst = 1'b0; entry_req = 1'b1; exit_req = 1'b1;
        expect_run("rp_post_reset_entry", 1, O_ENT_UP);
        entry_req = 1'b0; exit_req = 1'b0;
        tick();
        check_eq("rp_no_car_out", car_out_total - snap_out, 0);
        check_eq("no_overlap", overlap_total, 0);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
